// File: rtl/clb_config_ctrl_if.sv
// Bitstream load and readback stream bundle between a host and clb_config_ctrl.
// The slave modport is the controller side; the master modport is the host side.
interface clb_config_ctrl_if #(
  parameter int WORD_W = 8
) ();
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );
endinterface

// File: rtl/clb_config_ctrl.sv
// Configuration controller for a daisy-chain of CLB programming shift registers.
// LOAD serializes stream words LSB-first onto the chain; READBACK rotates the chain once and emits it as words.
module clb_config_ctrl #(
  parameter int NUM_CLB      = 4,
  parameter int BITS_PER_CLB = 17,
  parameter int WORD_W       = 8
) (
  input  logic             prog_clk,
  input  logic             prog_rst,
  input  logic             start_load,
  input  logic             start_readback,
  clb_config_ctrl_if.slave bus,
  input  logic             chain_out,
  output logic             prog_in_o,
  output logic             prog_en_o,
  output logic             busy,
  output logic             done
);
  localparam int CHAIN_LEN = NUM_CLB * BITS_PER_CLB;
  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
  localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W     = $clog2(WORD_W + 1);
  localparam int WRD_W     = $clog2(NUM_WORDS + 1);
  localparam int RBC_W     = $clog2(WORD_W + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_FULL   = BIT_W'(CHAIN_LEN);
  localparam logic [BUF_W-1:0] BUF_WORD   = BUF_W'(WORD_W);
  localparam logic [BUF_W-1:0] BUF_LAST   = BUF_W'(LAST_BITS);
  localparam logic [WRD_W-1:0] WRD_ALL    = WRD_W'(NUM_WORDS);
  localparam logic [WRD_W-1:0] WRD_LAST   = WRD_W'(NUM_WORDS - 1);
  localparam logic [RBC_W-1:0] RB_WORD_M1 = RBC_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, READBACK} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0]  buf_cnt_q, buf_cnt_d;
  logic [WRD_W-1:0]  words_q, words_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rb_sr_q, rb_sr_d;
  logic [RBC_W-1:0]  rb_cnt_q, rb_cnt_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;
  logic              done_q, done_d;
  logic              cfg_ready;

  always_ff @(posedge prog_clk) begin
    if (prog_rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      words_q    <= '0;
      bit_cnt_q  <= '0;
      rb_sr_q    <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      words_q    <= words_d;
      bit_cnt_q  <= bit_cnt_d;
      rb_sr_q    <= rb_sr_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    words_d    = words_q;
    bit_cnt_d  = bit_cnt_q;
    rb_sr_d    = rb_sr_q;
    rb_cnt_d   = rb_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = rb_valid_q;
    done_d     = 1'b0;
    cfg_ready  = 1'b0;
    prog_en_o  = 1'b0;
    prog_in_o  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_load || start_readback) begin
          state_d    = start_load ? LOAD : READBACK;
          buf_cnt_d  = '0;
          words_d    = '0;
          bit_cnt_d  = '0;
          rb_sr_d    = '0;
          rb_cnt_d   = '0;
          rb_valid_d = 1'b0;
        end
      end

      // Accept and shift never overlap: a new word is only taken once the buffer has drained.
      LOAD: begin
        cfg_ready = (buf_cnt_q == '0) && (words_q < WRD_ALL);
        if (buf_cnt_q != '0) begin
          prog_en_o = 1'b1;
          prog_in_o = buf_q[0];
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (bus.cfg_valid && cfg_ready) begin
          buf_d     = bus.cfg_data;
          buf_cnt_d = (words_q == WRD_LAST) ? BUF_LAST : BUF_WORD;
          words_d   = words_q + 1'b1;
        end
      end

      // The chain is fed its own output, so one full pass restores the configuration.
      READBACK: begin
        prog_in_o = chain_out;
        prog_en_o = !rb_valid_q;
        if (rb_valid_q) begin
          if (bus.rb_ready) begin
            rb_valid_d = 1'b0;
            if (bit_cnt_q == BIT_FULL) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          rb_sr_d   = rb_sr_q | (WORD_W'(chain_out) << rb_cnt_q);
          rb_cnt_d  = rb_cnt_q + 1'b1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if ((rb_cnt_q == RB_WORD_M1) || (bit_cnt_q == BIT_LAST)) begin
            rb_data_d  = rb_sr_d;
            rb_valid_d = 1'b1;
            rb_sr_d    = '0;
            rb_cnt_d   = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_valid  = rb_valid_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
endmodule

// File: tb/tb_clb_config_ctrl.sv
// Directed bench for clb_config_ctrl driving a behavioural 4x17-bit CLB chain model.
module tb_clb_config_ctrl;
  localparam int CHAIN_LEN = 68;
  localparam logic [CHAIN_LEN-1:0] EXP_CHAIN = 68'h9_08_07_06_05_04_03_02_01;

  logic prog_clk = 1'b0;
  logic prog_rst;
  logic start_load;
  logic start_readback;
  logic chain_out;
  logic prog_in_o;
  logic prog_en_o;
  logic busy;
  logic done;
  logic chainClear;
  logic [CHAIN_LEN-1:0] chain;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] loadWords [9];
  logic [7:0] expRb [9];
  logic [7:0] rbWords [9];

  clb_config_ctrl_if #(.WORD_W(8)) bus ();

  clb_config_ctrl dut (
    .prog_clk       (prog_clk),
    .prog_rst       (prog_rst),
    .start_load     (start_load),
    .start_readback (start_readback),
    .bus            (bus),
    .chain_out      (chain_out),
    .prog_in_o      (prog_in_o),
    .prog_en_o      (prog_en_o),
    .busy           (busy),
    .done           (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Whole chain as one register: CLB0 occupies the top 17 bits, the last CLB the bottom 17.
  always @(posedge prog_clk) begin
    if (chainClear) chain <= '0;
    else if (prog_en_o) chain <= {prog_in_o, chain[CHAIN_LEN-1:1]};
  end
  assign chain_out = chain[0];

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic checkResetState(input string prefix);
    checkBit({prefix, "Busy"}, busy, 1'b0);
    checkBit({prefix, "CfgReady"}, bus.cfg_ready, 1'b0);
    checkBit({prefix, "RbValid"}, bus.rb_valid, 1'b0);
    checkOutput({prefix, "RbData"}, 72'(bus.rb_data), 72'(0));
    checkBit({prefix, "ProgEn"}, prog_en_o, 1'b0);
    checkBit({prefix, "ProgIn"}, prog_in_o, 1'b0);
    checkBit({prefix, "Done"}, done, 1'b0);
  endtask

  task automatic clearChain();
    chainClear = 1'b1;
    tick();
    chainClear = 1'b0;
  endtask

  task automatic applyStimulusLoad(input int gapAt, input int gapLen, input bit bothStart, input bit midRb,
                                   output int enCycles, output int accepts, output int readyCycles,
                                   output int doneSeen, output logic busyAtDone);
    int idx;
    int gap;
    int cyc;
    bit finished;
    bit holding;
    bit accept;
    idx = 0; gap = 0; cyc = 0; finished = 0;
    enCycles = 0; accepts = 0; readyCycles = 0; doneSeen = 0; busyAtDone = 1'b1;
    start_load = 1'b1;
    start_readback = bothStart;
    tick();
    start_load = 1'b0;
    start_readback = 1'b0;
    checkBit("loadEntryBusy", busy, 1'b1);
    checkBit("loadEntryReady", bus.cfg_ready, 1'b1);
    while (!finished && cyc < 400) begin
      holding = (idx == gapAt) && (gap < gapLen);
      bus.cfg_data = loadWords[(idx < 9) ? idx : 8];
      bus.cfg_valid = (idx < 9) && !holding;
      start_readback = midRb && (cyc == 30);
      if (holding && bus.cfg_ready) begin
        gap++;
        checkBit("gapEnLow", prog_en_o, 1'b0);
      end
      accept = bus.cfg_valid && bus.cfg_ready;
      if (prog_en_o) enCycles++;
      if (bus.cfg_ready) readyCycles++;
      tick();
      cyc++;
      if (accept) begin
        idx++;
        accepts++;
      end
      if (done) begin
        doneSeen++;
        busyAtDone = busy;
        finished = 1;
      end
    end
    bus.cfg_valid = 1'b0;
    start_readback = 1'b0;
    tick();
    checkBit("loadDoneSingle", done, 1'b0);
  endtask

  task automatic applyStimulusReadback(input int stallWord, input int stallLen,
                                       output int enCycles, output int nWords, output int doneSeen);
    int cyc;
    int stall;
    bit finished;
    bit hold;
    cyc = 0; stall = 0; finished = 0;
    enCycles = 0; nWords = 0; doneSeen = 0;
    start_readback = 1'b1;
    tick();
    start_readback = 1'b0;
    checkBit("rbEntryBusy", busy, 1'b1);
    checkBit("rbEntryNoReady", bus.cfg_ready, 1'b0);
    while (!finished && cyc < 400) begin
      hold = (nWords == stallWord) && (stall < stallLen) && bus.rb_valid;
      bus.rb_ready = !hold;
      if (hold) begin
        checkOutput("stallData", 72'(bus.rb_data), 72'(expRb[stallWord]));
        checkBit("stallEnLow", prog_en_o, 1'b0);
        stall++;
      end
      if (prog_en_o) enCycles++;
      if (bus.rb_valid && bus.rb_ready) begin
        if (nWords < 9) rbWords[nWords] = bus.rb_data;
        nWords++;
      end
      tick();
      cyc++;
      if (done) begin
        doneSeen++;
        finished = 1;
      end
    end
    bus.rb_ready = 1'b0;
    tick();
    checkBit("rbDoneSingle", done, 1'b0);
  endtask

  task automatic checkReadbackWords(input string prefix);
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("%sWord%0d", prefix, i), 72'(rbWords[i]), 72'(expRb[i]));
  endtask

  initial begin
    int enCycles;
    int accepts;
    int readyCycles;
    int doneSeen;
    int nWords;
    int idx;
    int nShift;
    int cyc;
    bit accept;
    logic busyAtDone;
    logic [CHAIN_LEN-1:0] partialExp;

    for (int i = 0; i < 9; i++) begin
      loadWords[i] = 8'(i + 1);
      expRb[i] = 8'(i + 1);
      rbWords[i] = '0;
    end

    prog_rst = 1'b1;
    start_load = 1'b0;
    start_readback = 1'b0;
    bus.cfg_data = '0;
    bus.cfg_valid = 1'b0;
    bus.rb_ready = 1'b0;
    chainClear = 1'b1;
    repeat (3) tick();
    prog_rst = 1'b0;
    chainClear = 1'b0;
    checkResetState("reset");

    // Plain load of 0x01..0x09 with valid held high.
    applyStimulusLoad(-1, 0, 1'b0, 1'b0, enCycles, accepts, readyCycles, doneSeen, busyAtDone);
    checkOutput("loadEnCycles", 72'(enCycles), 72'(68));
    checkOutput("loadAccepts", 72'(accepts), 72'(9));
    checkOutput("loadReadyPulses", 72'(readyCycles), 72'(9));
    checkOutput("loadDoneCount", 72'(doneSeen), 72'(1));
    checkBit("loadBusyAtDone", busyAtDone, 1'b0);
    checkOutput("loadChain", 72'(chain), 72'(EXP_CHAIN));
    checkBit("lastClbBit0", chain[0], 1'b1);
    checkBit("clb0Bit16", chain[CHAIN_LEN-1], 1'b1);

    applyStimulusReadback(-1, 0, enCycles, nWords, doneSeen);
    checkOutput("rb1EnCycles", 72'(enCycles), 72'(68));
    checkOutput("rb1Words", 72'(nWords), 72'(9));
    checkOutput("rb1Done", 72'(doneSeen), 72'(1));
    checkReadbackWords("rb1");
    checkOutput("rb1Chain", 72'(chain), 72'(EXP_CHAIN));

    applyStimulusReadback(-1, 0, enCycles, nWords, doneSeen);
    checkOutput("rb2Words", 72'(nWords), 72'(9));
    checkReadbackWords("rb2");

    // Consumer holds off word 3 for five cycles.
    applyStimulusReadback(3, 5, enCycles, nWords, doneSeen);
    checkOutput("rbStallEnCycles", 72'(enCycles), 72'(68));
    checkOutput("rbStallDone", 72'(doneSeen), 72'(1));
    checkReadbackWords("rbStall");
    checkOutput("rbStallChain", 72'(chain), 72'(EXP_CHAIN));

    // Gap before word index 2; final word carries junk in its upper nibble.
    clearChain();
    loadWords[8] = 8'hA9;
    applyStimulusLoad(2, 4, 1'b0, 1'b0, enCycles, accepts, readyCycles, doneSeen, busyAtDone);
    loadWords[8] = 8'h09;
    checkOutput("gapEnCycles", 72'(enCycles), 72'(68));
    checkOutput("gapDone", 72'(doneSeen), 72'(1));
    checkOutput("gapChain", 72'(chain), 72'(EXP_CHAIN));

    // Reset in the middle of a load.
    clearChain();
    start_load = 1'b1;
    tick();
    start_load = 1'b0;
    idx = 0; nShift = 0; cyc = 0;
    while (nShift < 20 && cyc < 100) begin
      bus.cfg_data = loadWords[idx];
      bus.cfg_valid = 1'b1;
      accept = bus.cfg_ready;
      if (prog_en_o) nShift++;
      tick();
      cyc++;
      if (accept) idx++;
    end
    bus.cfg_valid = 1'b0;
    prog_rst = 1'b1;
    if (prog_en_o) nShift++;
    tick();
    prog_rst = 1'b0;
    checkResetState("midReset");
    partialExp = EXP_CHAIN << (CHAIN_LEN - nShift);
    checkOutput("partialChain", 72'(chain), 72'(partialExp));
    tick();
    checkBit("midResetStillIdle", busy, 1'b0);

    applyStimulusLoad(-1, 0, 1'b0, 1'b0, enCycles, accepts, readyCycles, doneSeen, busyAtDone);
    checkOutput("reloadEnCycles", 72'(enCycles), 72'(68));
    checkOutput("reloadChain", 72'(chain), 72'(EXP_CHAIN));

    // Both starts together pick LOAD; a readback request during LOAD is dropped.
    clearChain();
    applyStimulusLoad(-1, 0, 1'b1, 1'b1, enCycles, accepts, readyCycles, doneSeen, busyAtDone);
    checkOutput("bothEnCycles", 72'(enCycles), 72'(68));
    checkOutput("bothDone", 72'(doneSeen), 72'(1));
    checkOutput("bothChain", 72'(chain), 72'(EXP_CHAIN));
    for (int i = 0; i < 4; i++) begin
      tick();
      checkBit("noRbAfterLoadBusy", busy, 1'b0);
      checkBit("noRbAfterLoadEn", prog_en_o, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/clb_config_ctrl.md
Name: clb_config_ctrl

Overview:
- Configuration controller for a daisy-chain of NUM_CLB CLB programming shift registers, each BITS_PER_CLB bits wide. All run on prog_clk: controller prog_in_o feeds CLB0 prog_in, each CLB prog_out feeds the next CLB's prog_in, and the last CLB's prog_out returns as chain_out.
- LOAD mode: accepts bitstream words over a valid/ready stream and serializes them LSB-first onto the chain.
- READBACK mode: rotates the whole chain once, feeding chain_out back into the chain, and emits the captured bits as words. After readback the configuration is unchanged.

Parameters:
- NUM_CLB, 4, number of CLBs in the chain
- BITS_PER_CLB, 17, configuration bits per CLB
- WORD_W, 8, bitstream word width
- Derived, not overridable:
  - CHAIN_LEN = NUM_CLB*BITS_PER_CLB (68)
  - NUM_WORDS = ceil(CHAIN_LEN/WORD_W) (9)
  - LAST_BITS = CHAIN_LEN - (NUM_WORDS-1)*WORD_W (4)

Ports:
- prog_clk  in  1  sole clock, rising edge
- prog_rst  in  1  synchronous, active-high reset
- start_load  in  1  one-cycle request to begin LOAD
- start_readback  in  1  one-cycle request to begin READBACK
- cfg_data  in  WORD_W  bitstream word
- cfg_valid  in  1  cfg_data valid
- cfg_ready  out  1  controller accepts cfg_data
- rb_data  out  WORD_W  readback word
- rb_valid  out  1  rb_data valid
- rb_ready  in  1  consumer accepts rb_data
- chain_out  in  1  prog_out of the last CLB
- prog_in_o  out  1  to CLB0 prog_in
- prog_en_o  out  1  shift enable, to every CLB's prog_en
- busy  out  1  high in LOAD or READBACK
- done  out  1  one-cycle pulse when an operation completes

Behaviour:
- Clock and reset: single clock prog_clk. Reset prog_rst is synchronous, active-high.
- Reset values:
  - State = IDLE.
  - All counters 0, word buffer empty.
  - cfg_ready=0, rb_valid=0, rb_data=0, prog_en_o=0, prog_in_o=0, busy=0, done=0.
  - CLB chain contents are not touched by reset.
- States: IDLE, LOAD, READBACK.
- IDLE:
  - start_load=1 → LOAD.
  - Else start_readback=1 → READBACK.
  - If both are high together, LOAD wins.
- While busy, start_load and start_readback are ignored.
- LOAD:
  - Holds a one-word buffer: buf, with buf_cnt = bits remaining in buf.
  - cfg_ready = (buf_cnt==0) && (words_taken < NUM_WORDS). This is combinational from registers.
  - On a cycle with cfg_valid && cfg_ready:
    - buf <= cfg_data.
    - buf_cnt <= WORD_W, or LAST_BITS for word NUM_WORDS-1.
    - words_taken++.
  - While buf_cnt>0:
    - prog_en_o=1 and prog_in_o=buf[0].
    - At each edge: buf shifts right, buf_cnt--, bit_cnt++.
  - When prog_en_o=0, prog_in_o=0.
  - For the last word, bits above LAST_BITS are ignored.
  - Throughput: one word per WORD_W+1 cycles (one accept cycle, then WORD_W shift cycles).
  - A cfg_valid gap inserts idle cycles with prog_en_o=0. Chain contents hold.
  - Bit order: first bit shifted ends in last CLB bit 0; bit CHAIN_LEN-1 ends in CLB0 bit 16.
  - On the edge where bit_cnt reaches CHAIN_LEN: → IDLE, done=1 for the next cycle.
- READBACK:
  - prog_in_o = chain_out, combinational.
  - prog_en_o = !rb_valid.
  - Each enabled edge:
    - Capture chain_out into the rb shift register at bit position rb_cnt (LSB first).
    - rb_cnt++, bit_cnt++.
  - When rb_cnt reaches WORD_W, or LAST_BITS on the final word:
    - rb_data <= captured word, zero-padded above LAST_BITS on the final word.
    - rb_valid <= 1.
    - Shifting stalls.
  - rb_valid && rb_ready → rb_valid <= 0 and shifting resumes the next cycle.
  - rb_valid and rb_data stay stable until accepted.
  - Completion: after the final word is accepted with bit_cnt==CHAIN_LEN → IDLE, done pulse.
  - Exactly CHAIN_LEN enabled shifts occur, so the chain returns to its original contents.
  - The rb word sequence equals the word sequence that was loaded, with the final word masked.
- Counter widths: bit_cnt uses clog2(CHAIN_LEN+1) bits. There is no wrap-around; counters clear on entry to LOAD or READBACK.
- busy=1 in LOAD and READBACK, and in no other state.
- Reset mid-operation:
  - Immediate IDLE; prog_en_o=0 from the next cycle.
  - Chain keeps any partial contents.
  - Any pending rb word is dropped.

Test Plan:
- Load 9 words 0x01,0x02,…,0x09 with cfg_valid held high → exactly 68 cycles with prog_en_o=1, cfg_ready pulses once per 9 cycles, done pulses once, busy falls the same cycle. Last CLB shift_reg bit0=1 (first bit); upper nibble of 0x09 is discarded.
- After that load, readback with rb_ready=1 → rb words 0x01…0x08 then 0x09. Done pulses. A second readback returns an identical sequence.
- Readback with rb_ready low for 5 cycles on word 3 → rb_data stable and prog_en_o=0 during the stall. No bits lost; final chain contents are unchanged.
- Load with cfg_valid deasserted for 4 cycles between words 2 and 3 → prog_en_o low during the gap. Total enabled shifts stay 68 and the chain contents match the gap-free case.
- Assert prog_rst after 20 load bits → next cycle IDLE, all outputs at reset values. A new start_load then completes a full 68-bit load correctly.
- start_load and start_readback high together in IDLE → LOAD entered. A start_readback pulse during LOAD is ignored: no READBACK follows done.
